// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 pipeline: instruction width,
// opcode encodings and the fetch-to-decode packet.
package mips32_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_ADD   = 6'b000000;
  localparam logic [5:0] OPC_SUB   = 6'b000001;
  localparam logic [5:0] OPC_LW    = 6'b001000;
  localparam logic [5:0] OPC_SW    = 6'b001001;
  localparam logic [5:0] OPC_ADDI  = 6'b001010;
  localparam logic [5:0] OPC_BNEQZ = 6'b001101;
  localparam logic [5:0] OPC_BEQZ  = 6'b001110;
  localparam logic [5:0] OPC_HLT   = 6'b111111;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        npc;
  } fetch_pkt_t;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OPC_HLT;
  endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// Small fetch queue between IF and ID. Flush wins over push/pop; the head
// output shows the last popped packet while the queue is empty.
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  fetch_pkt_t               i_pkt,
  output fetch_pkt_t               o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  fetch_pkt_t      r_mem [DEPTH];
  fetch_pkt_t      r_last;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [PW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? r_last : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_last  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_pkt;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_last <= r_mem[r_rd];
        r_rd   <= r_rd + 1'b1;
      end
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mips32_fetch_stage.sv
// Instruction fetch: PC, halt flag, instruction memory and the fetch queue
// feeding decode over a valid/ready handshake.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          FQ_DEPTH   = 2,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk_x,
  input  logic        rst_n,
  input  logic        id_ready_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_npc_o,
  output logic        halted_o
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  // Preloaded by the environment; never reset.
  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  logic [31:0]        r_pc;
  logic               r_halted;
  logic [INSTR_W-1:0] w_instr;
  logic               w_fetch_en;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [CW-1:0]      w_count;
  fetch_pkt_t         w_push_pkt;
  fetch_pkt_t         w_head;

  assign w_instr    = mem[r_pc[AW-1:0]];
  assign w_pop      = if_valid_o && id_ready_i;
  // A pop frees a slot in the same cycle, so a full queue still streams.
  assign w_fetch_en = !r_halted && !br_taken_i && (!w_full || w_pop);
  assign w_push_pkt = '{instr: w_instr, npc: r_pc + 32'd1};

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (br_taken_i) begin
      r_pc     <= br_target_i;
      r_halted <= 1'b0;
    end else if (w_fetch_en) begin
      if (is_hlt(w_instr)) r_halted <= 1'b1;
      else                 r_pc     <= r_pc + 32'd1;
    end
  end

  mips32_fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk_x),
    .rst_n   (rst_n),
    .i_flush (br_taken_i),
    .i_push  (w_fetch_en),
    .i_pop   (w_pop),
    .i_pkt   (w_push_pkt),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign if_valid_o = !w_empty;
  assign if_instr_o = w_head.instr;
  assign if_npc_o   = w_head.npc;
  assign halted_o   = r_halted;

  a_count_bound: assert property (@(posedge clk_x) disable iff (!rst_n)
    w_count <= CW'(FQ_DEPTH));

endmodule
